pop_graph_render: RTL and testbench

//  Multi-channel population history plotter; parametrised successor of the single-trace stats overlay.

---
 rtl/pop_graph_render.sv | 206 ++++++++++++++++++++
 tb/tb_pop_graph_render.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_graph_render.sv
// Multi-channel population history plotter: per-channel event accumulation, sample ring buffer,
// auto-scaled trace rendering with axes. Two-stage render pipeline aligned with the cell layer.
module pop_graph_render #(
    parameter int unsigned NUM_CH        = 2,
    parameter int unsigned HISTORY_LEN   = 32,
    parameter int unsigned COL_W         = 4,
    parameter int unsigned GRAPH_H       = 128,
    parameter int unsigned ORIGIN_X      = 864,
    parameter int unsigned ORIGIN_Y      = 32,
    parameter int unsigned SAMPLE_FRAMES = 16,
    parameter int unsigned CNT_W         = 16,
    parameter logic [47:0] CH_COLOR      = {12'h00F, 12'hFF0, 12'hF00, 12'h0F0}
) (
    input  logic              clk_130mhz,
    input  logic              rst_n_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              cell_valid_in,
    input  logic [NUM_CH-1:0] event_in,
    input  logic              frame_done_in,
    input  logic              freeze_in,
    output logic [11:0]       pix_out,
    output logic              sample_valid_out,
    output logic [4:0]        scale_out
);

    localparam int unsigned PTR_W   = $clog2(HISTORY_LEN);
    localparam int unsigned COL_SH  = $clog2(COL_W);
    localparam int unsigned GRAPH_W = HISTORY_LEN * COL_W;
    localparam int unsigned FC_W    = (SAMPLE_FRAMES > 1) ? $clog2(SAMPLE_FRAMES) : 1;
    localparam int unsigned X_END   = ORIGIN_X + GRAPH_W;
    localparam int unsigned X_YAX   = ORIGIN_X - 1;
    localparam int unsigned Y_XAX   = ORIGIN_Y + GRAPH_H;
    localparam int unsigned Y_BOT   = ORIGIN_Y + GRAPH_H - 1;
    localparam int unsigned FC_LAST = SAMPLE_FRAMES - 1;
    localparam int unsigned PTR_END = HISTORY_LEN - 1;

    localparam logic [10:0]      X_LO     = ORIGIN_X[10:0];
    localparam logic [10:0]      X_HI     = X_END[10:0];
    localparam logic [10:0]      X_AXIS   = X_YAX[10:0];
    localparam logic [9:0]       Y_TOP    = ORIGIN_Y[9:0];
    localparam logic [9:0]       Y_AXIS   = Y_XAX[9:0];
    localparam logic [9:0]       Y_BASE   = Y_BOT[9:0];
    localparam logic [PTR_W:0]   FILL_MAX = HISTORY_LEN[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_END[PTR_W-1:0];
    localparam logic [FC_W-1:0]  FC_TOP   = FC_LAST[FC_W-1:0];
    localparam logic [CNT_W-1:0] CLAMP    = CNT_W'(GRAPH_H - 1);
    localparam logic [CNT_W-1:0] H_LIM    = CNT_W'(GRAPH_H);

    logic [CNT_W-1:0] r_acc   [NUM_CH];
    logic [CNT_W-1:0] w_new   [NUM_CH];
    logic [CNT_W-1:0] r_ring  [HISTORY_LEN][NUM_CH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_fill;
    logic [FC_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0] r_peak;
    logic [CNT_W-1:0] r_window_max;
    logic [CNT_W-1:0] w_new_max;
    logic [4:0]       r_scale;
    logic [4:0]       w_scale;
    logic             w_scale_found;
    logic             r_scale_upd;
    logic             r_sample_valid;
    logic             w_commit;
    logic             w_write;
    logic             w_wrap;

    logic             w_in_x;
    logic [10:0]      w_hoff;
    logic [PTR_W-1:0] w_col;
    logic [PTR_W-1:0] w_slot;
    logic [CNT_W-1:0] r_s1_sample [NUM_CH];
    logic             r_s1_col_valid;
    logic             r_s1_in_x;
    logic [10:0]      r_s1_h;
    logic [9:0]       r_s1_v;
    logic [CNT_W-1:0] w_shift [NUM_CH];
    logic [CNT_W-1:0] w_ypos  [NUM_CH];
    logic [9:0]       w_y     [NUM_CH];
    logic             w_hit;
    logic [11:0]      w_pix;
    logic [11:0]      r_pix;

    // Saturating per-channel increment; commit sees this value, so a same-cycle event is kept.
    always_comb begin
        w_commit  = frame_done_in && (r_frame_cnt == FC_TOP);
        w_write   = w_commit && !freeze_in;
        w_wrap    = (r_wr_ptr == PTR_LAST);
        w_new_max = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_new[c] = (r_acc[c] == '1) ? r_acc[c]
                                        : r_acc[c] + CNT_W'(cell_valid_in & event_in[c]);
            if (w_new[c] > w_new_max) w_new_max = w_new[c];
        end
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_frame_cnt <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
        end else begin
            if (frame_done_in) r_frame_cnt <= w_commit ? '0 : r_frame_cnt + 1'b1;
            for (int unsigned c = 0; c < NUM_CH; c++) r_acc[c] <= w_commit ? '0 : w_new[c];
        end
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
            for (int unsigned i = 0; i < HISTORY_LEN; i++)
                for (int unsigned c = 0; c < NUM_CH; c++) r_ring[i][c] <= '0;
        end else if (w_write) begin
            for (int unsigned c = 0; c < NUM_CH; c++) r_ring[r_wr_ptr][c] <= w_new[c];
            r_wr_ptr <= r_wr_ptr + 1'b1;
            if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
        end
    end

    // Peak decays once per ring lap: on wrap it keeps only the lap just completed.
    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_peak         <= '0;
            r_window_max   <= '0;
            r_sample_valid <= 1'b0;
            r_scale_upd    <= 1'b0;
            r_scale        <= '0;
        end else begin
            r_sample_valid <= w_write;
            r_scale_upd    <= w_commit;
            if (r_scale_upd) r_scale <= w_scale;
            if (w_write) begin
                if (w_wrap) begin
                    r_peak       <= (w_new_max > r_window_max) ? w_new_max : r_window_max;
                    r_window_max <= '0;
                end else begin
                    r_peak       <= (w_new_max > r_peak) ? w_new_max : r_peak;
                    r_window_max <= (w_new_max > r_window_max) ? w_new_max : r_window_max;
                end
            end
        end
    end

    always_comb begin
        w_scale       = 5'd31;
        w_scale_found = 1'b0;
        for (int unsigned s = 0; s < 32; s++) begin
            if (!w_scale_found && ((r_peak >> s) < H_LIM)) begin
                w_scale       = s[4:0];
                w_scale_found = 1'b1;
            end
        end
    end

    // Render stage 1: column lookup, oldest sample at the left edge.
    always_comb begin
        w_in_x = (hcount_in >= X_LO) && (hcount_in < X_HI);
        w_hoff = hcount_in - X_LO;
        w_col  = PTR_W'(w_hoff >> COL_SH);
        w_slot = r_wr_ptr - r_fill[PTR_W-1:0] + w_col;
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_s1_col_valid <= 1'b0;
            r_s1_in_x      <= 1'b0;
            r_s1_h         <= '0;
            r_s1_v         <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) r_s1_sample[c] <= '0;
        end else begin
            r_s1_col_valid <= ({1'b0, w_col} < r_fill);
            r_s1_in_x      <= w_in_x;
            r_s1_h         <= hcount_in;
            r_s1_v         <= vcount_in;
            for (int unsigned c = 0; c < NUM_CH; c++) r_s1_sample[c] <= r_ring[w_slot][c];
        end
    end

    // Render stage 2: traces over axes, lower channel index wins.
    always_comb begin
        w_pix = '0;
        w_hit = 1'b0;
        if ((r_s1_v == Y_AXIS && r_s1_in_x) ||
            (r_s1_h == X_AXIS && r_s1_v >= Y_TOP && r_s1_v <= Y_AXIS))
            w_pix = 12'hFFF;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            w_shift[c] = r_s1_sample[c] >> r_scale;
            w_ypos[c]  = (w_shift[c] > CLAMP) ? CLAMP : w_shift[c];
            w_y[c]     = Y_BASE - 10'(w_ypos[c]);
            if (!w_hit && r_s1_col_valid && r_s1_in_x && r_s1_v == w_y[c]) begin
                w_pix = CH_COLOR[c*12 +: 12];
                w_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) r_pix <= '0;
        else           r_pix <= w_pix;
    end

    assign pix_out          = r_pix;
    assign sample_valid_out = r_sample_valid;
    assign scale_out        = r_scale;

endmodule

// File: tb/tb_pop_graph_render.sv
// Scoreboard bench for pop_graph_render: driver pushes expected pixels/pulses, monitor pops and compares.
`timescale 1ns/1ps
module tb_pop_graph_render;

    localparam int unsigned SF = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        cell_valid = 1'b0;
    logic [1:0]  ev = '0;
    logic        frame_done = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] pix_out;
    logic        sample_valid_out;
    logic [4:0]  scale_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit probe_vld = 1'b0;
    int exp_pix_q[$];
    string pix_name_q[$];
    int pulse_q[$];
    int pulse_issued = 0;
    int pulse_seen = 0;

    pop_graph_render #(
        .NUM_CH(2), .HISTORY_LEN(32), .COL_W(4), .GRAPH_H(128),
        .ORIGIN_X(864), .ORIGIN_Y(32), .SAMPLE_FRAMES(SF), .CNT_W(12),
        .CH_COLOR({12'h00F, 12'hFF0, 12'hF00, 12'h0F0})
    ) dut (
        .clk_130mhz(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
        .cell_valid_in(cell_valid), .event_in(ev), .frame_done_in(frame_done),
        .freeze_in(freeze), .pix_out(pix_out), .sample_valid_out(sample_valid_out),
        .scale_out(scale_out)
    );

    always #4 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pixel for a probe appears two edges later; pulses matched in issue order.
    initial begin
        bit d1, d2;
        int e;
        string nm;
        d1 = 0; d2 = 0;
        forever begin
            @(posedge clk);
            d2 = d1;
            d1 = probe_vld;
            #1;
            if (d2) begin
                if (exp_pix_q.size() == 0) begin
                    check("pix_q_underflow", 1, 0);
                end else begin
                    e  = exp_pix_q.pop_front();
                    nm = pix_name_q.pop_front();
                    check(nm, int'(pix_out), e);
                end
            end
            if (sample_valid_out) begin
                pulse_seen++;
                if (pulse_q.size() == 0) check("unexpected_pulse", pulse_seen, 0);
                else check("pulse_order", pulse_seen, pulse_q.pop_front());
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic probe(input int h, input int v, input int exp, input string nm);
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        probe_vld = 1'b1;
        exp_pix_q.push_back(exp);
        pix_name_q.push_back(nm);
    endtask

    task automatic flush();
        int t;
        @(negedge clk);
        probe_vld = 1'b0;
        t = 0;
        while (exp_pix_q.size() != 0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("pix_q_drain", exp_pix_q.size(), 0);
    endtask

    task automatic do_frame(input int p0, input int p1);
        int n;
        n = (p0 > p1) ? p0 : p1;
        if (n == 0) begin
            @(negedge clk); frame_done = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                cell_valid = 1'b1;
                ev[0] = (i < p0);
                ev[1] = (i < p1);
                frame_done = (i == n - 1);
            end
        end
        @(negedge clk);
        cell_valid = 1'b0; ev = '0; frame_done = 1'b0;
    endtask

    // One sample period: events spread over SF frames, final event coincides with commit.
    task automatic sample(input int e0, input int e1, input bit frz);
        freeze = frz;
        for (int f = 0; f < int'(SF); f++) begin
            int p0, p1;
            p0 = e0 / int'(SF) + ((f == int'(SF) - 1) ? e0 % int'(SF) : 0);
            p1 = e1 / int'(SF) + ((f == int'(SF) - 1) ? e1 % int'(SF) : 0);
            if (f == int'(SF) - 1 && !frz) begin
                pulse_issued++;
                pulse_q.push_back(pulse_issued);
            end
            do_frame(p0, p1);
        end
        freeze = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse_issued = 0;
        pulse_seen = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pix", int'(pix_out), 0);
        check("rst_valid", int'(sample_valid_out), 0);
        check("rst_scale", int'(scale_out), 0);
        rst_n = 1'b1;

        // Three empty frames: no commit, axes only.
        repeat (3) do_frame(0, 0);
        repeat (3) @(negedge clk);
        probe(900, 100, 12'h000, "t1_inside_empty");
        probe(900, 160, 12'hFFF, "t1_x_axis");
        probe(863, 100, 12'hFFF, "t1_y_axis");
        probe(863, 160, 12'hFFF, "t1_axis_corner");
        probe(863, 161, 12'h000, "t1_below_y_axis");
        probe(863, 31,  12'h000, "t1_above_y_axis");
        probe(864, 159, 12'h000, "t1_no_col_valid");
        probe(992, 160, 12'h000, "t1_right_of_x");
        flush();
        check("t1_scale", int'(scale_out), 0);
        reset_dut();

        // Five samples of 100 on ch0.
        repeat (5) sample(100, 0, 1'b0);
        check("t2_scale", int'(scale_out), 0);
        probe(864, 59,  12'h0F0, "t2_col0_ch0");
        probe(883, 59,  12'h0F0, "t2_col4_ch0");
        probe(884, 59,  12'h000, "t2_col5_empty");
        probe(864, 58,  12'h000, "t2_above_trace");
        probe(870, 159, 12'hF00, "t2_col1_ch1");
        probe(884, 159, 12'h000, "t2_col5_ch1_empty");
        flush();

        // Saturation: 2^12+5 events -> 4095, scale 5.
        sample(4101, 0, 1'b0);
        check("t3_scale", int'(scale_out), 5);
        probe(884, 32,  12'h0F0, "t3_sat_top");
        probe(864, 156, 12'h0F0, "t3_old_rescaled");
        probe(864, 59,  12'h000, "t3_old_pos_gone");
        probe(887, 159, 12'hF00, "t3_col5_ch1");
        probe(888, 32,  12'h000, "t3_col6_empty");
        probe(888, 160, 12'hFFF, "t3_x_axis");
        flush();

        // Wrap and peak decay: samples k=1..64, spike of 250 at k=2.
        reset_dut();
        for (int k = 1; k <= 64; k++) begin
            sample((k == 2) ? 250 : k, 0, 1'b0);
            if (k == 35) begin
                check("t4_scale_k35", int'(scale_out), 1);
                probe(864, 157, 12'h0F0, "t4_leftmost_s4");
                probe(864, 158, 12'h000, "t4_leftmost_not_s3");
                probe(980, 143, 12'h0F0, "t4_col29_s33");
                probe(988, 142, 12'h0F0, "t4_col31_s35");
                probe(864, 159, 12'hF00, "t4_ch1_zero");
                flush();
            end
            if (k == 63) check("t4_scale_k63", int'(scale_out), 1);
        end
        check("t4_scale_decayed", int'(scale_out), 0);
        probe(864, 126, 12'h0F0, "t4_col0_s33");
        probe(988, 95,  12'h0F0, "t4_col31_s64");
        flush();

        // Freeze discards the commit; next sample counts from zero.
        sample(20, 0, 1'b1);
        check("t5_scale_frozen", int'(scale_out), 0);
        probe(864, 126, 12'h0F0, "t5_frozen_col0");
        probe(988, 95,  12'h0F0, "t5_frozen_col31");
        flush();
        sample(7, 0, 1'b0);
        probe(864, 125, 12'h0F0, "t5_col0_s34");
        probe(864, 126, 12'h000, "t5_col0_old_gone");
        probe(988, 152, 12'h0F0, "t5_col31_fresh7");
        flush();

        // Equal channels: ch0 color wins; scale 2.
        sample(300, 300, 1'b0);
        check("t6_scale", int'(scale_out), 2);
        probe(988, 84,  12'h0F0, "t6_equal_prio");
        probe(984, 158, 12'h0F0, "t6_col30_ch0");
        probe(984, 159, 12'hF00, "t6_col30_ch1");
        probe(864, 151, 12'h0F0, "t6_col0_s35");
        flush();

        // Asynchronous reset mid-frame.
        @(negedge clk);
        hcount = 11'd988; vcount = 10'd84;
        cell_valid = 1'b1; ev = 2'b11;
        repeat (3) @(negedge clk);
        check("t6_pix_pre_reset", int'(pix_out), 12'h0F0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_pix", int'(pix_out), 0);
        check("t6_async_scale", int'(scale_out), 0);
        check("t6_async_valid", int'(sample_valid_out), 0);
        @(negedge clk);
        cell_valid = 1'b0; ev = '0;
        rst_n = 1'b1;
        pulse_issued = 0;
        pulse_seen = 0;
        probe(988, 84,  12'h000, "t6_post_rst_empty");
        probe(864, 159, 12'h000, "t6_post_rst_col0");
        probe(900, 160, 12'hFFF, "t6_post_rst_axis");
        flush();
        sample(10, 0, 1'b0);
        check("t6_post_scale", int'(scale_out), 0);
        probe(864, 149, 12'h0F0, "t6_post_first");
        probe(868, 149, 12'h000, "t6_post_col1_empty");
        flush();

        repeat (4) @(negedge clk);
        check("pulse_q_drain", pulse_q.size(), 0);
        check("pulse_count", pulse_seen, pulse_issued);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
